uart_rx: RTL and testbench

Serial receive stage for the console UART: samples the asynchronous `UART_RX` pin (GPIO_0[1]), deframes 8N1 characters and buffers them in a small show-ahead FIFO. It sits directly upstream of `hwregs`, which reads and pops bytes and exposes the error flags as a CPU-visible status register.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, character width and
// small helpers used by the console UART blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Next value of a sticky status flag; a clear wins over a set in the
  // same cycle so software never loses a clear to a racing event.
  function automatic logic sticky_next(input logic flag,
                                       input logic set,
                                       input logic clear);
    logic result;
    if (clear) begin
      result = 1'b0;
    end else if (set) begin
      result = 1'b1;
    end else begin
      result = flag;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count. The head entry is
// visible on 'head' whenever 'empty' is low; a pop advances it with no
// read latency. A push while full is accepted only if a pop happens in the
// same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign empty = (count_r == {(AW+1){1'b0}});
  assign full  = (count_r == FULL_COUNT);
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Decide which of the requested operations actually take effect.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  // Storage, pointers (wrap naturally, depth is a power of two) and count.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Console UART receiver: two-flop synchroniser on the pin, 8N1 deframing
// FSM with mid-bit sampling, sticky framing/overrun flags and a show-ahead
// byte FIFO read by the register block.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 434,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          UART_RX,
  input  logic                          rx_pop,
  input  logic                          clear_errors,
  output logic [7:0]                    rx_data,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_framing_error,
  output logic                          rx_overrun
);

  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic                      sync1_r;
  logic                      rxs_r;
  uart_rx_state_t            state_r;
  uart_rx_state_t            state_nxt_s;
  logic [TW-1:0]             timer_r;
  logic [TW-1:0]             timer_nxt_s;
  logic [2:0]                bit_cnt_r;
  logic [2:0]                bit_cnt_nxt_s;
  logic [UART_DATA_BITS-1:0] shift_r;
  logic [UART_DATA_BITS-1:0] shift_nxt_s;
  logic                      expired_s;
  logic                      push_s;
  logic                      frame_set_s;
  logic                      overrun_set_s;
  logic                      framing_r;
  logic                      overrun_r;
  logic                      fifo_full_s;

  assign expired_s = (timer_r == {TW{1'b0}});

  // Bring the asynchronous pin into the clock domain; idle level is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= UART_RX;
      rxs_r   <= sync1_r;
    end
  end

  // Deframing FSM: next state, bit timer, bit counter and shift register.
  always_comb begin
    state_nxt_s   = state_r;
    timer_nxt_s   = timer_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    push_s        = 1'b0;
    frame_set_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rxs_r) begin
          timer_nxt_s = HALF_LOAD;
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (!expired_s) begin
          timer_nxt_s = timer_r - TW'(1);
        end else if (rxs_r) begin
          // Line went back high before mid start bit: treat as noise.
          state_nxt_s = IDLE;
        end else begin
          timer_nxt_s   = FULL_LOAD;
          bit_cnt_nxt_s = 3'd0;
          state_nxt_s   = DATA;
        end
      end
      DATA: begin
        if (!expired_s) begin
          timer_nxt_s = timer_r - TW'(1);
        end else begin
          shift_nxt_s = {rxs_r, shift_r[UART_DATA_BITS-1:1]};
          timer_nxt_s = FULL_LOAD;
          if (bit_cnt_r == LAST_BIT) begin
            state_nxt_s = STOP;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          end
        end
      end
      STOP: begin
        if (!expired_s) begin
          timer_nxt_s = timer_r - TW'(1);
        end else if (rxs_r) begin
          push_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          // Bad stop bit: drop the byte and wait out any break condition.
          frame_set_s = 1'b1;
          state_nxt_s = BREAK;
        end
      end
      BREAK: begin
        if (rxs_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BREAK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      timer_r   <= {TW{1'b0}};
      bit_cnt_r <= 3'd0;
      shift_r   <= {UART_DATA_BITS{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      timer_r   <= timer_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
    end
  end

  // A good byte is lost only if the FIFO is full and nothing leaves it.
  always_comb begin
    overrun_set_s = push_s & fifo_full_s & ~rx_pop;
  end

  // Sticky error flags; clear_errors wins over a same-cycle set.
  always_ff @(posedge clock) begin
    if (reset) begin
      framing_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      framing_r <= sticky_next(framing_r, frame_set_s, clear_errors);
      overrun_r <= sticky_next(overrun_r, overrun_set_s, clear_errors);
    end
  end

  assign rx_framing_error = framing_r;
  assign rx_overrun       = overrun_r;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (shift_r),
    .pop       (rx_pop),
    .head      (rx_data),
    .empty     (rx_empty),
    .full      (fifo_full_s),
    .count     (rx_count)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLOCKS_PER_BIT=8, FIFO_DEPTH=4.
module tb_uart_rx;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic       UART_RX;
  logic       rx_pop;
  logic       clear_errors;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic [2:0] rx_count;
  logic       rx_framing_error;
  logic       rx_overrun;

  int checks;
  int errors;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_count;
    logic [7:0] exp_head;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[5];

  uart_rx #(
    .CLOCKS_PER_BIT (CPB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .UART_RX          (UART_RX),
    .rx_pop           (rx_pop),
    .clear_errors     (clear_errors),
    .rx_data          (rx_data),
    .rx_empty         (rx_empty),
    .rx_count         (rx_count),
    .rx_framing_error (rx_framing_error),
    .rx_overrun       (rx_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one 8N1 frame (80 cycles); optionally pulse rx_pop at cycle pop_at.
  task automatic send_byte(input logic [7:0] data, input logic stop_bit, input int pop_at);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      UART_RX = frame[c / CPB];
      rx_pop  = (c == pop_at);
      tick();
    end
    rx_pop = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, {31'd0, rx_empty}, 32'd0);
    check(name, {24'd0, rx_data}, {24'd0, exp});
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
  endtask

  initial begin
    logic [9:0] frame;
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    UART_RX      = 1'b1;
    rx_pop       = 1'b0;
    clear_errors = 1'b0;

    vecs[0] = '{data: 8'h01, stop_bit: 1'b1, exp_count: 1, exp_head: 8'h01, exp_ovr: 1'b0};
    vecs[1] = '{data: 8'h02, stop_bit: 1'b1, exp_count: 2, exp_head: 8'h01, exp_ovr: 1'b0};
    vecs[2] = '{data: 8'h03, stop_bit: 1'b1, exp_count: 3, exp_head: 8'h01, exp_ovr: 1'b0};
    vecs[3] = '{data: 8'h04, stop_bit: 1'b1, exp_count: 4, exp_head: 8'h01, exp_ovr: 1'b0};
    vecs[4] = '{data: 8'h05, stop_bit: 1'b1, exp_count: 4, exp_head: 8'h01, exp_ovr: 1'b1};

    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset values
    check("reset_empty", {31'd0, rx_empty}, 32'd1);
    check("reset_count", {29'd0, rx_count}, 32'd0);
    check("reset_data",  {24'd0, rx_data}, 32'd0);
    check("reset_fe",    {31'd0, rx_framing_error}, 32'd0);
    check("reset_ovr",   {31'd0, rx_overrun}, 32'd0);

    // 1. Single character with exact push latency
    frame = {1'b1, 8'hA5, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      UART_RX = frame[c / CPB];
      tick();
      if (c == 77) check("t1_empty_before", {31'd0, rx_empty}, 32'd1);
      if (c == 78) begin
        check("t1_empty_at79", {31'd0, rx_empty}, 32'd0);
        check("t1_data", {24'd0, rx_data}, 32'h0000_00A5);
        check("t1_count", {29'd0, rx_count}, 32'd1);
      end
    end
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    check("t1_empty_after_pop", {31'd0, rx_empty}, 32'd1);

    // 2. Glitch rejection, then a normal byte is still received
    UART_RX = 1'b0;
    repeat (2) tick();
    UART_RX = 1'b1;
    repeat (20) tick();
    check("t2_empty", {31'd0, rx_empty}, 32'd1);
    check("t2_fe", {31'd0, rx_framing_error}, 32'd0);
    check("t2_ovr", {31'd0, rx_overrun}, 32'd0);
    send_byte(8'hC3, 1'b1, -1);
    check("t2_count", {29'd0, rx_count}, 32'd1);
    pop_check("t2_data", 8'hC3);

    // 3. Framing error followed by a break, recovery and clear
    send_byte(8'h3C, 1'b0, -1);
    repeat (40) tick();
    check("t3_fe", {31'd0, rx_framing_error}, 32'd1);
    check("t3_count", {29'd0, rx_count}, 32'd0);
    UART_RX = 1'b1;
    repeat (4) tick();
    send_byte(8'h11, 1'b1, -1);
    check("t3_count_after", {29'd0, rx_count}, 32'd1);
    check("t3_fe_held", {31'd0, rx_framing_error}, 32'd1);
    pop_check("t3_data", 8'h11);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    check("t3_fe_cleared", {31'd0, rx_framing_error}, 32'd0);

    // 3b. Clear held across the error-setting cycle wins
    clear_errors = 1'b1;
    send_byte(8'h3C, 1'b0, -1);
    tick();
    clear_errors = 1'b0;
    UART_RX = 1'b1;
    repeat (4) tick();
    check("t3b_fe_clear_priority", {31'd0, rx_framing_error}, 32'd0);

    // 4. Overrun, table-driven
    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].data, vecs[i].stop_bit, -1);
      tick();
      check($sformatf("t4_count_%0d", i), {29'd0, rx_count}, 32'(vecs[i].exp_count));
      check($sformatf("t4_head_%0d", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_head});
      check($sformatf("t4_ovr_%0d", i), {31'd0, rx_overrun}, {31'd0, vecs[i].exp_ovr});
    end
    for (int i = 0; i < 4; i++) begin
      pop_check($sformatf("t4_pop_%0d", i), vecs[i].data);
    end
    check("t4_empty", {31'd0, rx_empty}, 32'd1);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    check("t4_ovr_cleared", {31'd0, rx_overrun}, 32'd0);

    // 5. Push and pop in the same cycle while full
    send_byte(8'hA1, 1'b1, -1);
    send_byte(8'hA2, 1'b1, -1);
    send_byte(8'hA3, 1'b1, -1);
    send_byte(8'hA4, 1'b1, -1);
    check("t5_full", {29'd0, rx_count}, 32'd4);
    send_byte(8'h77, 1'b1, 78);
    check("t5_count", {29'd0, rx_count}, 32'd4);
    check("t5_ovr", {31'd0, rx_overrun}, 32'd0);
    pop_check("t5_pop0", 8'hA2);
    pop_check("t5_pop1", 8'hA3);
    pop_check("t5_pop2", 8'hA4);
    pop_check("t5_pop3", 8'h77);
    check("t5_empty", {31'd0, rx_empty}, 32'd1);

    // 5b. Push and pop in the same cycle while empty: pop ignored
    send_byte(8'h3E, 1'b1, 78);
    check("t5b_count", {29'd0, rx_count}, 32'd1);
    check("t5b_data", {24'd0, rx_data}, 32'h0000_003E);

    // 6. Reset during data bit 3 (FIFO holds 3E going in)
    frame = {1'b1, 8'h96, 1'b0};
    for (int c = 0; c < 36; c++) begin
      UART_RX = frame[c / CPB];
      tick();
    end
    reset   = 1'b1;
    UART_RX = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("t6_empty", {31'd0, rx_empty}, 32'd1);
    check("t6_count", {29'd0, rx_count}, 32'd0);
    check("t6_data", {24'd0, rx_data}, 32'd0);
    check("t6_fe", {31'd0, rx_framing_error}, 32'd0);
    check("t6_ovr", {31'd0, rx_overrun}, 32'd0);
    repeat (4) tick();
    send_byte(8'h5A, 1'b1, -1);
    check("t6_count_after", {29'd0, rx_count}, 32'd1);
    pop_check("t6_data_after", 8'h5A);
    check("t6_fe_after", {31'd0, rx_framing_error}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
